// File: rtl/nes_fetch_ctrl.sv
// Instruction-fetch sequencer for the NES 6502 core: owns the PC, issues byte
// reads, assembles 1-3 byte instructions and hands them to decode.
module nes_fetch_ctrl #(
    parameter int unsigned       ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BOOT_ADDR = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_rdata_i,
    input  logic              mem_rvalid_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [23:0]       instr_o,
    output logic [1:0]        instr_len_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    output logic              illegal_o,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [ADDR_W-1:0] pc_o
);

    typedef enum logic [1:0] {
        FETCH_OPCODE      = 2'd0,
        FETCH_ABS_B0      = 2'd1,
        FETCH_ABS_B1      = 2'd2,
        FETCH_INSTR_READY = 2'd3
    } fetch_state_t;

    localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PC_ZERO = {ADDR_W{1'b0}};

    // Returns {illegal, length} for an opcode using the documented NMOS 6502 set.
    function automatic logic [2:0] decode_len(input logic [7:0] op);
        logic [2:0] res;
        case (op)
            8'h00, 8'h08, 8'h0A, 8'h18, 8'h28, 8'h2A, 8'h38, 8'h40,
            8'h48, 8'h4A, 8'h58, 8'h60, 8'h68, 8'h6A, 8'h78, 8'h88,
            8'h8A, 8'h98, 8'h9A, 8'hA8, 8'hAA, 8'hB8, 8'hBA, 8'hC8,
            8'hCA, 8'hD8, 8'hE8, 8'hEA, 8'hF8:
                res = {1'b0, 2'd1};
            8'h01, 8'h05, 8'h09, 8'h11, 8'h15, 8'h21, 8'h25, 8'h29,
            8'h31, 8'h35, 8'h41, 8'h45, 8'h49, 8'h51, 8'h55, 8'h61,
            8'h65, 8'h69, 8'h71, 8'h75, 8'h81, 8'h85, 8'h91, 8'h95,
            8'hA1, 8'hA5, 8'hA9, 8'hB1, 8'hB5, 8'hC1, 8'hC5, 8'hC9,
            8'hD1, 8'hD5, 8'hE1, 8'hE5, 8'hE9, 8'hF1, 8'hF5,
            8'h06, 8'h16, 8'h26, 8'h36, 8'h46, 8'h56, 8'h66, 8'h76,
            8'h86, 8'h96, 8'hA2, 8'hA6, 8'hB6, 8'hC6, 8'hD6, 8'hE6,
            8'hF6, 8'h24, 8'h84, 8'h94, 8'hA0, 8'hA4, 8'hB4, 8'hC0,
            8'hC4, 8'hE0, 8'hE4,
            8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0:
                res = {1'b0, 2'd2};
            8'h0D, 8'h19, 8'h1D, 8'h2D, 8'h39, 8'h3D, 8'h4D, 8'h59,
            8'h5D, 8'h6D, 8'h79, 8'h7D, 8'h8D, 8'h99, 8'h9D, 8'hAD,
            8'hB9, 8'hBD, 8'hCD, 8'hD9, 8'hDD, 8'hED, 8'hF9, 8'hFD,
            8'h0E, 8'h1E, 8'h2E, 8'h3E, 8'h4E, 8'h5E, 8'h6E, 8'h7E,
            8'h8E, 8'hAE, 8'hBE, 8'hCE, 8'hDE, 8'hEE, 8'hFE,
            8'h20, 8'h2C, 8'h4C, 8'h6C, 8'h8C, 8'hAC, 8'hBC, 8'hCC,
            8'hEC:
                res = {1'b0, 2'd3};
            default:
                res = {1'b1, 2'd1};
        endcase
        return res;
    endfunction

    fetch_state_t      state_r, next_state_s;
    logic [ADDR_W-1:0] pc_r, next_pc_s, mem_addr_r, instr_pc_r;
    logic              pending_r, discard_r, mem_rd_r, instr_valid_r, illegal_r;
    logic [23:0]       instr_r;
    logic [1:0]        len_r;
    logic              rsp_s, capture_s, pending_after_s, issue_s, discard_next_s;
    logic [2:0]        dec_s;

    // Response bookkeeping: a stale (discarded) or redirect-coincident response
    // still retires the outstanding read but never lands in the instruction.
    always_comb begin
        dec_s           = decode_len(mem_rdata_i);
        rsp_s           = mem_rvalid_i & pending_r;
        capture_s       = rsp_s & ~discard_r & ~redirect_i & (state_r != FETCH_INSTR_READY);
        pending_after_s = pending_r & ~rsp_s;
        discard_next_s  = (discard_r & ~rsp_s) | (redirect_i & pending_r & ~mem_rvalid_i);
    end

    // Next-state and next-PC selection; redirect overrides everything.
    always_comb begin
        next_state_s = state_r;
        next_pc_s    = pc_r;
        case (state_r)
            FETCH_OPCODE: begin
                if (capture_s) begin
                    next_state_s = (dec_s[1:0] == 2'd1) ? FETCH_INSTR_READY : FETCH_ABS_B0;
                end else begin
                    next_state_s = FETCH_OPCODE;
                end
            end
            FETCH_ABS_B0: begin
                if (capture_s) begin
                    next_state_s = (len_r == 2'd2) ? FETCH_INSTR_READY : FETCH_ABS_B1;
                end else begin
                    next_state_s = FETCH_ABS_B0;
                end
            end
            FETCH_ABS_B1: begin
                if (capture_s) begin
                    next_state_s = FETCH_INSTR_READY;
                end else begin
                    next_state_s = FETCH_ABS_B1;
                end
            end
            FETCH_INSTR_READY: begin
                if (instr_ready_i) begin
                    next_state_s = FETCH_OPCODE;
                end else begin
                    next_state_s = FETCH_INSTR_READY;
                end
            end
            default: next_state_s = FETCH_OPCODE;
        endcase
        if (redirect_i) begin
            next_state_s = FETCH_OPCODE;
            next_pc_s    = redirect_pc_i;
        end else if (capture_s) begin
            next_pc_s = pc_r + PC_ONE;
        end else begin
            next_pc_s = pc_r;
        end
    end

    // The next read launches on the same edge that retires the previous one.
    always_comb begin
        issue_s = ~redirect_i & ~pending_after_s & (next_state_s != FETCH_INSTR_READY);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= FETCH_OPCODE;
            pc_r          <= BOOT_ADDR;
            pending_r     <= 1'b0;
            discard_r     <= 1'b0;
            mem_rd_r      <= 1'b0;
            mem_addr_r    <= PC_ZERO;
            instr_valid_r <= 1'b0;
            instr_r       <= 24'h000000;
            len_r         <= 2'd0;
            instr_pc_r    <= PC_ZERO;
            illegal_r     <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            pc_r          <= next_pc_s;
            pending_r     <= pending_after_s | issue_s;
            discard_r     <= discard_next_s;
            mem_rd_r      <= issue_s;
            mem_addr_r    <= issue_s ? next_pc_s : PC_ZERO;
            instr_valid_r <= (next_state_s == FETCH_INSTR_READY);
            if (issue_s && (next_state_s == FETCH_OPCODE)) begin
                instr_pc_r <= next_pc_s;
            end
            if (capture_s) begin
                case (state_r)
                    FETCH_OPCODE: begin
                        instr_r   <= {16'h0000, mem_rdata_i};
                        len_r     <= dec_s[1:0];
                        illegal_r <= dec_s[2];
                    end
                    FETCH_ABS_B0: instr_r[15:8]  <= mem_rdata_i;
                    FETCH_ABS_B1: instr_r[23:16] <= mem_rdata_i;
                    default:      instr_r        <= instr_r;
                endcase
            end
        end
    end

    assign mem_rd_o      = mem_rd_r;
    assign mem_addr_o    = mem_addr_r;
    assign instr_valid_o = instr_valid_r;
    assign instr_o       = instr_r;
    assign instr_len_o   = len_r;
    assign instr_pc_o    = instr_pc_r;
    assign illegal_o     = illegal_r;
    assign pc_o          = pc_r;

endmodule

// File: tb/tb_nes_fetch_ctrl.sv
// Directed bench for nes_fetch_ctrl: a table of opcode vectors plus hand-written
// sequences for wrap, back-pressure, redirect races, slow memory and reset.
module tb_nes_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd_o;
    logic [15:0] mem_addr_o;
    logic [7:0]  mem_rdata_i;
    logic        mem_rvalid_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [23:0] instr_o;
    logic [1:0]  instr_len_o;
    logic [15:0] instr_pc_o;
    logic        illegal_o;
    logic        redirect_i;
    logic [15:0] redirect_pc_i;
    logic [15:0] pc_o;

    nes_fetch_ctrl dut (
        .clk(clk), .rst(rst),
        .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o),
        .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .instr_len_o(instr_len_o), .instr_pc_o(instr_pc_o),
        .illegal_o(illegal_o), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .pc_o(pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  b0, b1, b2;
        logic [23:0] exp_instr;
        logic [1:0]  exp_len;
        logic        exp_ill;
    } vec_t;

    vec_t        vecs[15];
    logic [7:0]  mem[0:65535];
    logic [15:0] rd_log[$];
    int          checks = 0;
    int          failures = 0;
    int          lat = 1;
    int          cnt = 0;
    bit          busy = 1'b0;
    logic [15:0] raddr = 16'h0000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock; then the memory model drives this cycle's response.
    task automatic tick();
        @(posedge clk);
        #1;
        mem_rvalid_i = 1'b0;
        if (busy) begin
            cnt--;
            if (cnt == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mem[raddr];
                busy         = 1'b0;
            end
        end
        if (mem_rd_o) begin
            busy  = 1'b1;
            cnt   = lat;
            raddr = mem_addr_o;
            rd_log.push_back(mem_addr_o);
        end
    endtask

    task automatic redirect(input logic [15:0] a);
        redirect_i    = 1'b1;
        redirect_pc_i = a;
        tick();
        redirect_i    = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!instr_valid_o && n < 40) begin
            tick();
            n++;
        end
        chk({nm, "_valid_timeout"}, 32'(instr_valid_o), 32'd1);
    endtask

    task automatic wait_read(input string nm, input logic [15:0] a);
        int n = 0;
        while (!(mem_rd_o && mem_addr_o == a) && n < 40) begin
            tick();
            n++;
        end
        chk({nm, "_read_timeout"}, 32'(mem_rd_o && mem_addr_o == a), 32'd1);
    endtask

    task automatic chk_log(input string nm, input int n, input logic [15:0] a0,
                           input logic [15:0] a1, input logic [15:0] a2);
        logic [15:0] e[3];
        e = '{a0, a1, a2};
        chk({nm, "_nreads"}, 32'(rd_log.size()), 32'(n));
        for (int i = 0; i < n && i < rd_log.size(); i++)
            chk($sformatf("%s_read%0d", nm, i), 32'(rd_log[i]), 32'(e[i]));
    endtask

    task automatic accept();
        instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int early;
        int n;
        vecs[0]  = '{16'h1000, 8'hEA, 8'h5A, 8'hC3, 24'h0000EA, 2'd1, 1'b0};
        vecs[1]  = '{16'h1010, 8'hA9, 8'h05, 8'hC3, 24'h0005A9, 2'd2, 1'b0};
        vecs[2]  = '{16'h1020, 8'hAD, 8'h34, 8'h12, 24'h1234AD, 2'd3, 1'b0};
        vecs[3]  = '{16'h1030, 8'h02, 8'h5A, 8'hC3, 24'h000002, 2'd1, 1'b1};
        vecs[4]  = '{16'h1040, 8'h00, 8'h5A, 8'hC3, 24'h000000, 2'd1, 1'b0};
        vecs[5]  = '{16'h1050, 8'h6C, 8'h00, 8'h02, 24'h02006C, 2'd3, 1'b0};
        vecs[6]  = '{16'h1060, 8'hD0, 8'hFE, 8'hC3, 24'h00FED0, 2'd2, 1'b0};
        vecs[7]  = '{16'h1070, 8'h9E, 8'h5A, 8'hC3, 24'h00009E, 2'd1, 1'b1};
        vecs[8]  = '{16'h1080, 8'hB6, 8'h10, 8'hC3, 24'h0010B6, 2'd2, 1'b0};
        vecs[9]  = '{16'h1090, 8'h89, 8'h5A, 8'hC3, 24'h000089, 2'd1, 1'b1};
        vecs[10] = '{16'h10A0, 8'h20, 8'h00, 8'hC0, 24'hC00020, 2'd3, 1'b0};
        vecs[11] = '{16'h10B0, 8'h0A, 8'h5A, 8'hC3, 24'h00000A, 2'd1, 1'b0};
        vecs[12] = '{16'h10C0, 8'h91, 8'h44, 8'hC3, 24'h004491, 2'd2, 1'b0};
        vecs[13] = '{16'h10D0, 8'hBE, 8'h00, 8'h30, 24'h3000BE, 2'd3, 1'b0};
        vecs[14] = '{16'h10E0, 8'hFF, 8'h5A, 8'hC3, 24'h0000FF, 2'd1, 1'b1};
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0000] = 8'hEA;
        rst = 1'b1; instr_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 16'h0000;
        mem_rvalid_i = 1'b0; mem_rdata_i = 8'h00;

        // Reset state, then first fetch from BOOT_ADDR.
        tick(); tick();
        chk("rst_rd", 32'(mem_rd_o), 32'd0);
        chk("rst_addr", 32'(mem_addr_o), 32'h0);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_instr", 32'(instr_o), 32'h0);
        chk("rst_len", 32'(instr_len_o), 32'd0);
        chk("rst_ipc", 32'(instr_pc_o), 32'h0);
        chk("rst_ill", 32'(illegal_o), 32'd0);
        chk("rst_pc", 32'(pc_o), 32'h0000);
        rst = 1'b0;
        tick();
        chk("boot_rd", 32'(mem_rd_o), 32'd1);
        chk("boot_addr", 32'(mem_addr_o), 32'h0000);
        tick();
        chk("boot_valid_early", 32'(instr_valid_o), 32'd0);
        tick();
        chk("boot_valid", 32'(instr_valid_o), 32'd1);
        chk("boot_instr", 32'(instr_o), 32'h0000EA);
        chk("boot_len", 32'(instr_len_o), 32'd1);
        chk("boot_ipc", 32'(instr_pc_o), 32'h0000);
        accept();
        chk("boot_next_rd", 32'(mem_rd_o), 32'd1);
        chk("boot_next_addr", 32'(mem_addr_o), 32'h0001);
        chk("boot_valid_drop", 32'(instr_valid_o), 32'd0);

        // Absolute instruction via redirect.
        wait_valid("t2_pre");
        mem[16'h0010] = 8'hAD; mem[16'h0011] = 8'h34; mem[16'h0012] = 8'h12;
        rd_log.delete();
        redirect(16'h0010);
        chk("t2_redir_rd", 32'(mem_rd_o), 32'd0);
        wait_valid("t2");
        chk_log("t2", 3, 16'h0010, 16'h0011, 16'h0012);
        chk("t2_instr", 32'(instr_o), 32'h1234AD);
        chk("t2_len", 32'(instr_len_o), 32'd3);
        chk("t2_ipc", 32'(instr_pc_o), 32'h0010);
        accept();
        chk("t2_next_addr", 32'(mem_rd_o ? mem_addr_o : 16'hDEAD), 32'h0013);

        // Back-pressure: outputs hold, no reads until accept.
        wait_valid("t3_pre");
        mem[16'h0020] = 8'hA9; mem[16'h0021] = 8'h05;
        redirect(16'h0020);
        wait_valid("t3");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t3_hold%0d_valid", i), 32'(instr_valid_o), 32'd1);
            chk($sformatf("t3_hold%0d_instr", i), 32'(instr_o), 32'h0005A9);
            chk($sformatf("t3_hold%0d_len", i), 32'(instr_len_o), 32'd2);
            chk($sformatf("t3_hold%0d_rd", i), 32'(mem_rd_o), 32'd0);
        end
        accept();
        chk("t3_next_addr", 32'(mem_rd_o ? mem_addr_o : 16'hDEAD), 32'h0022);

        // PC wrap across FFFF.
        wait_valid("t4_pre");
        mem[16'hFFFE] = 8'h4C; mem[16'hFFFF] = 8'h00; mem[16'h0000] = 8'h80;
        rd_log.delete();
        redirect(16'hFFFE);
        wait_valid("t4");
        chk_log("t4", 3, 16'hFFFE, 16'hFFFF, 16'h0000);
        chk("t4_instr", 32'(instr_o), 32'h80004C);
        chk("t4_ipc", 32'(instr_pc_o), 32'hFFFE);
        chk("t4_pc", 32'(pc_o), 32'h0001);

        // Opcode table.
        for (int i = 0; i < 15; i++) begin
            mem[vecs[i].addr]         = vecs[i].b0;
            mem[vecs[i].addr + 16'd1] = vecs[i].b1;
            mem[vecs[i].addr + 16'd2] = vecs[i].b2;
            redirect(vecs[i].addr);
            wait_valid($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_instr", i), 32'(instr_o), 32'(vecs[i].exp_instr));
            chk($sformatf("vec%0d_len", i), 32'(instr_len_o), 32'(vecs[i].exp_len));
            chk($sformatf("vec%0d_ill", i), 32'(illegal_o), 32'(vecs[i].exp_ill));
            chk($sformatf("vec%0d_ipc", i), 32'(instr_pc_o), 32'(vecs[i].addr));
            chk($sformatf("vec%0d_pc", i), 32'(pc_o), 32'(vecs[i].addr + 16'(vecs[i].exp_len)));
        end

        // Redirect coincident with a handshake: redirect PC wins.
        mem[16'h0400] = 8'hEA;
        instr_ready_i = 1'b1;
        redirect(16'h0400);
        instr_ready_i = 1'b0;
        chk("hs_redir_valid", 32'(instr_valid_o), 32'd0);
        chk("hs_redir_pc", 32'(pc_o), 32'h0400);
        chk("hs_redir_rd", 32'(mem_rd_o), 32'd0);
        wait_valid("hs_redir");
        chk("hs_redir_ipc", 32'(instr_pc_o), 32'h0400);
        chk("hs_redir_instr", 32'(instr_o), 32'h0000EA);

        // Redirect coincident with rvalid: byte dropped, no discard left behind.
        mem[16'h0500] = 8'hC8; mem[16'h0510] = 8'hA9; mem[16'h0511] = 8'h11;
        redirect(16'h0500);
        wait_read("rv_redir", 16'h0500);
        tick();
        rd_log.delete();
        redirect(16'h0510);
        wait_valid("rv_redir");
        chk("rv_redir_instr", 32'(instr_o), 32'h0011A9);
        chk("rv_redir_ipc", 32'(instr_pc_o), 32'h0510);
        chk_log("rv_redir", 2, 16'h0510, 16'h0511, 16'h0000);

        // Slow memory: redirect while the opcode read at 0005 is pending.
        lat = 3;
        mem[16'h0005] = 8'hEA; mem[16'h0200] = 8'hA2; mem[16'h0201] = 8'h7F;
        redirect(16'h0005);
        wait_read("slow", 16'h0005);
        rd_log.delete();
        redirect(16'h0200);
        early = 0; n = 0;
        while (!mem_rvalid_i && n < 10) begin
            tick();
            n++;
            if (mem_rd_o) early++;
        end
        chk("slow_stale_rsp_seen", 32'(mem_rvalid_i), 32'd1);
        chk("slow_early_reads", 32'(early), 32'd0);
        wait_valid("slow");
        chk_log("slow", 2, 16'h0200, 16'h0201, 16'h0000);
        chk("slow_instr", 32'(instr_o), 32'h007FA2);
        chk("slow_len", 32'(instr_len_o), 32'd2);
        chk("slow_ipc", 32'(instr_pc_o), 32'h0200);

        // Reset during the operand-high read; the late response must be ignored.
        mem[16'h0300] = 8'h8D; mem[16'h0301] = 8'h00; mem[16'h0302] = 8'h04;
        redirect(16'h0300);
        wait_read("mrst", 16'h0302);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_rd", 32'(mem_rd_o), 32'd0);
        chk("mrst_addr", 32'(mem_addr_o), 32'h0);
        chk("mrst_valid", 32'(instr_valid_o), 32'd0);
        chk("mrst_instr", 32'(instr_o), 32'h0);
        chk("mrst_len", 32'(instr_len_o), 32'd0);
        chk("mrst_ill", 32'(illegal_o), 32'd0);
        chk("mrst_ipc", 32'(instr_pc_o), 32'h0);
        chk("mrst_pc", 32'(pc_o), 32'h0000);
        tick();
        chk("mrst_boot_rd", 32'(mem_rd_o), 32'd1);
        chk("mrst_boot_addr", 32'(mem_addr_o), 32'h0000);
        wait_valid("mrst");
        chk("mrst_instr_after", 32'(instr_o), 32'h000080);
        chk("mrst_ill_after", 32'(illegal_o), 32'd1);
        chk("mrst_len_after", 32'(instr_len_o), 32'd1);
        chk("mrst_ipc_after", 32'(instr_pc_o), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nes_fetch_ctrl.md
Name: nes_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the NES 6502 core.
- Owns the program counter and issues byte reads to the 16-bit memory port.
- Assembles 1–3-byte instructions (opcode + operand bytes) and hands each to decode with a valid/ready handshake.
- Accepts redirects (jump/branch/interrupt vector) from execute, cancelling any fetch in flight.

Parameters:
- ADDR_W, 16, memory address width; equals the package MEM_ADDR_SIZE.
- BOOT_ADDR, 16'h0000, PC value after reset; equals the package BOOT_ADDR.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_rd_o  out  1  one-cycle read-request pulse.
- mem_addr_o  out  ADDR_W  read address; valid when mem_rd_o=1, otherwise 0.
- mem_rdata_i  in  8  read data; valid when mem_rvalid_i=1.
- mem_rvalid_i  in  1  read response; arrives ≥1 cycle after the request.
- instr_valid_o  out  1  assembled instruction available.
- instr_ready_i  in  1  decode accepts the instruction.
- instr_o  out  24  [7:0] opcode, [15:8] operand low, [23:16] operand high; unused bytes are 0.
- instr_len_o  out  2  instruction length, 1..3.
- instr_pc_o  out  ADDR_W  address of the opcode byte.
- illegal_o  out  1  opcode is not a documented 6502 opcode; qualified by instr_valid_o.
- redirect_i  in  1  load a new PC.
- redirect_pc_i  in  ADDR_W  new PC.
- pc_o  out  ADDR_W  address of the next byte to fetch.

Behaviour:
- FSM uses the package fetch_state_t: FETCH_OPCODE, FETCH_ABS_B0, FETCH_ABS_B1, FETCH_INSTR_READY.
- Reset:
  - state=FETCH_OPCODE, pc=BOOT_ADDR, pending=0, discard=0.
  - All outputs 0, except pc_o=BOOT_ADDR.
  - Reset mid-operation abandons everything; a response arriving after reset is ignored because pending=0.
- At most one read is outstanding. Internal flag pending is set on mem_rd_o and cleared on mem_rvalid_i.
- Fetch states (FETCH_OPCODE, FETCH_ABS_B0, FETCH_ABS_B1):
  - When pending=0 and no redirect: pulse mem_rd_o with mem_addr_o=pc.
  - On mem_rvalid_i: capture the byte into the corresponding instr_o slot and set pc=pc+1, wrapping 16'hFFFF→16'h0000.
- Length decode on opcode capture uses the standard NMOS 6502 table:
  - implied/accumulator → 1
  - immediate/zero-page/(zp,X)/(zp),Y/relative → 2
  - absolute/abs-indexed/indirect → 3
  - BRK (00) → 1
  - undocumented opcodes → 1, with illegal_o=1
- Transitions:
  - FETCH_OPCODE → FETCH_INSTR_READY when len=1, else → FETCH_ABS_B0.
  - FETCH_ABS_B0 → FETCH_INSTR_READY when len=2, else → FETCH_ABS_B1.
  - FETCH_ABS_B1 → FETCH_INSTR_READY.
  - Each transition occurs on the response capture.
- FETCH_INSTR_READY:
  - instr_valid_o=1; instr_o, instr_len_o, instr_pc_o, illegal_o held stable.
  - On instr_valid_o & instr_ready_i: go to FETCH_OPCODE; the next read issues the following cycle.
  - With 1-cycle memory, a 1-byte instruction shows valid 2 cycles after its read pulse.
- Redirect (highest priority, any state):
  - pc←redirect_pc_i; state←FETCH_OPCODE; instr_valid_o=0 from the next cycle.
  - No read is issued in the redirect cycle.
  - If a read is pending and its rvalid is not in this same cycle, set discard. The next mem_rvalid_i is then dropped, clearing pending and discard.
  - The new read issues only once pending=0.
  - rvalid coincident with redirect: the data is dropped; discard is not set.
  - Redirect coincident with a valid/ready handshake: the handshake counts as consumed; the redirect PC wins.
- mem_rvalid_i while pending=0 is ignored.
- instr_pc_o latches pc at opcode request time; it wraps like pc.

Test Plan:
- Reset, BOOT_ADDR=0, 1-cycle memory with byte EA at 0000 → mem_rd_o at 0000 on the first post-reset cycle; instr_valid_o with instr_o=0x0000EA, len=1, instr_pc_o=0000; next read at 0001.
- Bytes AD 34 12 at 0010 via redirect to 0010 → reads at 0010/0011/0012; instr_o=0x1234AD, len=3; next read at 0013.
- instr_ready_i held low for 5 cycles with A9 05 valid → outputs stable at 0x0005A9, len=2; no mem_rd_o until accept.
- Redirect to FFFE with 4C 00 80 at FFFE/FFFF/0000 → reads wrap FFFF→0000; instr_o=0x80004C, instr_pc_o=FFFE; pc_o=0001.
- 3-cycle-latency memory, redirect to 0200 while the opcode read at 0005 is pending → stale response dropped; first read at 0200 only after it returns; delivered instr_pc_o=0200.
- Opcode 02 → illegal_o=1, len=1. Separately, rst asserted mid-way through FETCH_ABS_B1 → next cycle all outputs 0, pc_o=BOOT_ADDR, and the late rvalid is ignored.
